band_seq_ctrl: RTL and testbench
================================

// Module: band_seq_ctrl
// PURPOSE
//  Sequencer for the ROM-coefficient FIR band filters (all bands share one timebase).
//  Owns the circular sample-queue addressing and generates the 'sequencing' strobe per new sample.
//  Issues queue read addresses aligned with each band's coefficient ROM address.
//  Pulses filt_vld when band outputs are valid.
//  Sits between the audio sample source and the left/right band filters.
// PARAMETERS
//  DEPTH    1024  queue entries (power of 2); pointers wrap DEPTH-1 -> 0
//  ADDR_W   10    log2(DEPTH); width of wr_addr/rd_addr
//  TAPS     1021  filter taps = samples needed before first sequencing run
//  SEQ_LEN  1023  cycles 'sequencing' stays high per run (band addr 0..SEQ_LEN-1)
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       asynchronous reset, active-low
//  smpl_vld    in   1       1-cycle pulse: new left/right sample pair present this cycle
//  clr_err     in   1       clears ovr_err
//  wr_en       out  1       queue write enable (comb: smpl_vld & accepted)
//  wr_addr     out  ADDR_W  queue write address (= wr_ptr)
//  rd_addr     out  ADDR_W  queue read address (registered), presented to queue RAM
//  sequencing  out  1       run strobe to all band filters
//  filt_vld    out  1       1-cycle pulse: band filter outputs valid
//  busy        out  1       high in SEQ state
//  ovr_err     out  1       sticky: sample dropped because a run was in progress
// BEHAVIOUR
//  Reset (async): state=FILL, fill_cnt=0, wr_ptr=0, rd_addr=0, seq_cnt=0;
//   sequencing=0, filt_vld=0, busy=0, ovr_err=0, wr_en=0.
//  States:
//   FILL: accept every smpl_vld; fill_cnt++ (saturates at TAPS).
//    Accept when fill_cnt==TAPS-1 -> SEQ next cycle; else stay.
//   IDLE: accept smpl_vld -> SEQ next cycle.
//   SEQ: sequencing=1, busy=1; seq_cnt 0..SEQ_LEN-1.
//    At seq_cnt==SEQ_LEN-1: filt_vld=1 for that cycle only -> DONE.
//   DONE: exactly 1 cycle, sequencing=0 (lets the bands' rising-edge detect re-arm).
//    Accept smpl_vld -> SEQ next cycle; else -> IDLE.
//  Accept: wr_en=1, wr_addr=wr_ptr, wr_ptr<=wr_ptr+1 mod DEPTH, in the same cycle.
//  Sample in SEQ: dropped; wr_en=0; wr_ptr unchanged; ovr_err<=1; no state change.
//  ovr_err: cleared by clr_err. A same-cycle set and clr_err leaves ovr_err=1 (set wins).
//  rd_addr:
//   On entry to SEQ, rd_addr<=wr_ptr-TAPS (mod DEPTH), using wr_ptr after the triggering write,
//    i.e. the oldest of the last TAPS samples.
//   Increments by 1 (mod DEPTH) every SEQ cycle; holds otherwise.
//   Queue RAM read latency is 1 cycle, matching the coefficient ROM.
//  Arithmetic: all pointer math is unsigned ADDR_W bits; wrap is implicit modulo DEPTH.
//  seq_cnt is ADDR_W bits; SEQ_LEN <= DEPTH.
//  filt_vld coincides with band address == SEQ_LEN-1 (1022), i.e. the band output-valid cycle.
//  Reset mid-run: all outputs drop immediately; the queue is treated as empty (full refill required).
//  sequencing/busy/filt_vld are registered from state (no combinational path from smpl_vld).
// TESTING
//  1. Reset; 1020 smpl_vld pulses spaced 2000 cycles -> sequencing stays 0, wr_addr 0..1019.
//     1021st pulse -> sequencing=1 the next cycle for exactly 1023 cycles.
//     filt_vld pulses once, on the last of those cycles.
//  2. Start address: first run rd_addr starts 0 (wr_ptr=1021); next sample -> run starts rd_addr=1.
//     rd_addr increments each SEQ cycle, wrapping 1023->0.
//  3. Wrap: after 1024 accepted samples, wr_addr of the 1025th write = 0.
//     rd_addr start = (wr_ptr-1021) mod 1024.
//  4. Overrun: smpl_vld at seq_cnt=500 -> wr_en=0, wr_ptr unchanged, ovr_err=1, run unaffected.
//     clr_err -> 0; clr_err concurrent with another overrun -> ovr_err stays 1.
//  5. Back-to-back: smpl_vld in the DONE cycle -> accepted (wr_en=1).
//     sequencing low exactly 1 cycle, then high for a new 1023-cycle run.
//  6. rst_n low at seq_cnt=300 -> sequencing/busy/filt_vld=0 immediately.
//     After release, 1020 samples produce no run; the 1021st does.

Source files
------------

// File: rtl/band_seq_ctrl.sv
// band_seq_ctrl: shared-timebase sequencer for the ROM-coefficient FIR band
// filters. It owns the circular sample-queue pointers, launches one
// SEQ_LEN-cycle filter run per accepted sample once TAPS samples are queued,
// and flags samples that arrive while a run is still in progress.
module band_seq_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TAPS    = 1021,
  parameter int SEQ_LEN = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_vld,
  input  logic              clr_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sequencing,
  output logic              filt_vld,
  output logic              busy,
  output logic              ovr_err
);

  typedef enum logic [1:0] {FILL, IDLE, SEQ, DONE} state_t;

  localparam logic [ADDR_W-1:0] TAPS_A    = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] TAPS_LAST = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] SEQ_LAST  = ADDR_W'(SEQ_LEN - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] seq_cnt_q, seq_cnt_d;
  logic              seq_q, seq_d;
  logic              filt_vld_q, filt_vld_d;
  logic              ovr_err_q, ovr_err_d;
  logic              accept;
  logic              drop;

  // Circular pointer step; wraps DEPTH-1 back to 0.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Next-state, queue pointer and run-counter logic.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_addr_d  = rd_addr_q;
    seq_cnt_d  = seq_cnt_q;
    accept     = 1'b0;
    drop       = 1'b0;

    case (state_q)
      FILL: begin
        if (smpl_vld) begin
          accept = 1'b1;
          if (fill_cnt_q != TAPS_A) fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == TAPS_LAST) state_d = SEQ;
        end
      end
      IDLE: begin
        if (smpl_vld) begin
          accept  = 1'b1;
          state_d = SEQ;
        end
      end
      SEQ: begin
        drop      = smpl_vld;
        rd_addr_d = ptr_inc(rd_addr_q);
        seq_cnt_d = seq_cnt_q + 1'b1;
        if (seq_cnt_q == SEQ_LAST) begin
          state_d   = DONE;
          seq_cnt_d = '0;
        end
      end
      DONE: begin
        // One cycle with sequencing low so the bands' edge detectors re-arm.
        if (smpl_vld) begin
          accept  = 1'b1;
          state_d = SEQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = FILL;
    endcase

    if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);

    // A new run reads from the oldest of the last TAPS samples, counting the
    // sample written in the triggering cycle.
    if ((state_q != SEQ) && (state_d == SEQ)) begin
      rd_addr_d = wr_ptr_d - TAPS_A;
      seq_cnt_d = '0;
    end

    seq_d      = (state_d == SEQ);
    filt_vld_d = (state_d == SEQ) && (seq_cnt_d == SEQ_LAST);
    ovr_err_d  = drop | (ovr_err_q & ~clr_err);
  end

  // State and datapath registers; asynchronous reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_addr_q  <= '0;
      seq_cnt_q  <= '0;
      seq_q      <= 1'b0;
      filt_vld_q <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_addr_q  <= rd_addr_d;
      seq_cnt_q  <= seq_cnt_d;
      seq_q      <= seq_d;
      filt_vld_q <= filt_vld_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign wr_en      = accept;
  assign wr_addr    = wr_ptr_q;
  assign rd_addr    = rd_addr_q;
  assign sequencing = seq_q;
  assign busy       = seq_q;
  assign filt_vld   = filt_vld_q;
  assign ovr_err    = ovr_err_q;

endmodule

// File: tb/tb_band_seq_ctrl.sv
// tb_band_seq_ctrl: randomized stimulus for band_seq_ctrl with a scoreboard.
// The stimulus side models the sequencer as timing arithmetic (a run occupies
// cycles rs..rs+SEQ_LEN-1 after an accepted sample once TAPS samples are held)
// and queues expected writes, run starts and ovr_err values; a negedge monitor
// pops and compares whenever the DUT presents the corresponding output.
module tb_band_seq_ctrl;
  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;
  localparam int TAPS    = 1021;
  localparam int SEQ_LEN = 1023;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              smpl_vld = 1'b0;
  logic              clr_err = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              sequencing;
  logic              filt_vld;
  logic              busy;
  logic              ovr_err;

  band_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAPS(TAPS), .SEQ_LEN(SEQ_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .clr_err(clr_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .sequencing(sequencing),
    .filt_vld(filt_vld), .busy(busy), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; } ev_t;

  ev_t exp_run[$];
  ev_t exp_ovr[$];
  int  exp_wr[$];

  int cyc = 0;
  int passed = 0;
  int total = 0;

  // model state
  int  n_acc = 0;
  int  rs = 0;
  bit  run_valid = 1'b0;
  bit  ovr_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic report(input string name, input string what);
    total++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // One stimulus cycle: apply inputs, predict the response, advance a clock.
  task automatic drive(input bit sv, input bit clr);
    int  k;
    bit  in_run;
    bit  drop;
    ev_t e;
    k = cyc;
    smpl_vld = sv;
    clr_err  = clr;
    in_run = run_valid && (k >= rs) && (k <= rs + SEQ_LEN - 1);
    drop   = sv && in_run;
    if (sv && !in_run) begin
      exp_wr.push_back(n_acc % DEPTH);
      n_acc++;
      if (n_acc >= TAPS) begin
        rs = k + 1;
        run_valid = 1'b1;
        e.cyc = rs;
        e.val = (n_acc - TAPS) % DEPTH;
        exp_run.push_back(e);
      end
    end
    if (drop || clr) begin
      ovr_m = drop | (ovr_m & ~clr);
      e.cyc = k + 1;
      e.val = int'(ovr_m);
      exp_ovr.push_back(e);
    end
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) drive(1'b0, 1'b0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
    end
  endtask

  // Monitor: pops expectations as the DUT presents writes, runs and flags.
  bit prev_seq = 1'b0;
  bit in_run_mon = 1'b0;
  int run_len = 0;
  int run_start = 0;
  int fv_cnt = 0;
  always @(negedge clk) begin
    ev_t r;
    int  w;
    if (!rst_n) begin
      prev_seq   = 1'b0;
      in_run_mon = 1'b0;
    end else begin
      if (wr_en) begin
        if (exp_wr.size() == 0) report("wr_en", "write with no accepted sample expected");
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", int'(wr_addr), w);
        end
      end
      if (exp_ovr.size() != 0 && exp_ovr[0].cyc == cyc) begin
        r = exp_ovr.pop_front();
        check("ovr_err", int'(ovr_err), r.val);
      end
      if (sequencing && !prev_seq) begin
        if (exp_run.size() == 0) report("run_start", "sequencing rose with no run expected");
        else begin
          r = exp_run.pop_front();
          check("run_start_cyc", cyc, r.cyc);
          check("run_rd_start", int'(rd_addr), r.val);
          check("busy_in_run", int'(busy), 1);
          run_start = r.val;
        end
        in_run_mon = 1'b1;
        run_len = 1;
        fv_cnt = 0;
      end else if (sequencing && in_run_mon) begin
        run_len++;
        check("rd_addr_step", int'(rd_addr), (run_start + run_len - 1) % DEPTH);
      end else if (!sequencing && prev_seq && in_run_mon) begin
        check("run_len", run_len, SEQ_LEN);
        check("filt_vld_cnt", fv_cnt, 1);
        check("busy_after_run", int'(busy), 0);
        in_run_mon = 1'b0;
      end
      if (filt_vld) begin
        fv_cnt++;
        if (!sequencing) report("filt_vld", "pulse outside a run");
        else check("filt_vld_pos", run_len, SEQ_LEN);
      end
      prev_seq = sequencing;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_sequencing", int'(sequencing), 0);
    check("rst_filt_vld", int'(filt_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr_err", int'(ovr_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Initial fill: 1020 samples, no run; the 1021st triggers the first run.
    fill(TAPS - 1);
    check("fill_no_run", int'(sequencing), 0);
    drive(1'b1, 1'b0);

    // Episodes: overrun/clear, back-to-back, and random traffic.
    for (int e = 0; e < 12; e++) begin
      if (run_valid) wait_until(rs + SEQ_LEN + 1);
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      v = (e < 2) ? e : int'($urandom_range(0, 2));
      case (v)
        0: begin
          wait_until(rs + 500);
          drive(1'b1, 1'b0);
          wait_until(rs + 600);
          drive(1'b0, 1'b1);
          wait_until(rs + 700);
          drive(1'b1, 1'b1);
        end
        1: begin
          wait_until(rs + SEQ_LEN);
          drive(1'b1, 1'b0);
        end
        default: begin
          for (int i = 0; i < 1100; i++)
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
        end
      endcase
    end

    // Reset in the middle of a run.
    wait_until(rs + SEQ_LEN + 1);
    drive(1'b1, 1'b0);
    wait_until(rs + 300);
    rst_n = 1'b0;
    #1;
    check("midrst_sequencing", int'(sequencing), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_filt_vld", int'(filt_vld), 0);
    check("midrst_rd_addr", int'(rd_addr), 0);
    check("midrst_ovr_err", int'(ovr_err), 0);
    n_acc = 0;
    run_valid = 1'b0;
    ovr_m = 1'b0;
    exp_ovr.delete();
    exp_wr.delete();
    exp_run.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill(TAPS - 1);
    check("refill_no_run", int'(sequencing), 0);
    drive(1'b1, 1'b0);
    wait_until(rs + SEQ_LEN + 4);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("run_queue_drained", exp_run.size(), 0);
    check("ovr_queue_drained", exp_ovr.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
